usb_rx_bit_decoder: RTL

USB_RX_BIT_DECODER -- requirements
Module: usb_rx_bit_decoder

---
 rtl/usb_rx_pkg.sv | 37 +++
 rtl/usb_nrzi_decoder.sv | 31 +++
 rtl/usb_rx_bit_decoder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types and defaults for the USB receive bit decoder.
// Line-state codes are the raw {dp, dm} pair.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_K   = 2'b01,
    LS_J   = 2'b10,
    LS_SE1 = 2'b11
  } line_state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP
  } rx_state_t;

  typedef struct packed {
    logic serial;
    logic shift;
    logic rx_active;
    logic sop;
    logic eop;
    logic stuff_err;
    logic line_err;
    logic align_err;
  } rx_out_t;

  localparam int unsigned DEF_STUFF_LEN      = 6;
  localparam int unsigned DEF_SYNC_MIN_ZEROS = 5;

  function automatic line_state_t classify(input logic dp, input logic dm);
    return line_state_t'({dp, dm});
  endfunction

endpackage

// File: rtl/usb_nrzi_decoder.sv
// Classifies the synchronized dp/dm pair and NRZI-decodes it against the
// previously sampled line state.
module usb_nrzi_decoder
  import usb_rx_pkg::*;
(
  input  logic        clk,
  input  logic        nRST,
  input  logic        sample_en_i,
  input  logic        dp_i,
  input  logic        dm_i,
  input  logic        force_j_i,
  output line_state_t line_o,
  output logic        bit_o
);

  line_state_t prev_q;

  assign line_o = classify(dp_i, dm_i);
  // No transition decodes as 1, a J/K transition as 0.
  assign bit_o  = (line_o == prev_q);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (!nRST) begin
      prev_q <= LS_J;
    end else if (sample_en_i) begin
      prev_q <= force_j_i ? LS_J : line_o;
    end
  end

endmodule

// File: rtl/usb_rx_bit_decoder.sv
// USB receive bit decoder: SYNC detection, bit unstuffing, EOP detection
// and error reporting; every output is registered.
module usb_rx_bit_decoder
  import usb_rx_pkg::*;
#(
  parameter int unsigned STUFF_LEN      = DEF_STUFF_LEN,
  parameter int unsigned SYNC_MIN_ZEROS = DEF_SYNC_MIN_ZEROS
) (
  input  logic clk,
  input  logic nRST,
  input  logic sample_en,
  input  logic dp,
  input  logic dm,
  output logic serial_out,
  output logic shift_enable,
  output logic rx_active,
  output logic sop,
  output logic eop,
  output logic stuff_err,
  output logic line_err,
  output logic align_err
);

  localparam int unsigned       ONES_W    = $clog2(STUFF_LEN + 1);
  localparam logic [ONES_W-1:0] STUFF_MAX = ONES_W'(STUFF_LEN);

  rx_state_t         state_q, state_d;
  logic [2:0]        zero_cnt_q, zero_cnt_d;
  logic [ONES_W-1:0] ones_cnt_q, ones_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [1:0]        se0_cnt_q, se0_cnt_d;
  rx_out_t           out_q, out_d;

  line_state_t line;
  logic        dec_bit;
  logic        force_j;

  usb_nrzi_decoder u_nrzi (
    .clk        (clk),
    .nRST       (nRST),
    .sample_en_i(sample_en),
    .dp_i       (dp),
    .dm_i       (dm),
    .force_j_i  (force_j),
    .line_o     (line),
    .bit_o      (dec_bit)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d         = state_q;
    zero_cnt_d      = zero_cnt_q;
    ones_cnt_d      = ones_cnt_q;
    bit_cnt_d       = bit_cnt_q;
    se0_cnt_d       = se0_cnt_q;
    out_d           = '0;
    out_d.rx_active = out_q.rx_active;

    if (sample_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (line == LS_K) begin
            state_d    = ST_SYNC;
            zero_cnt_d = 3'd1;
          end
        end
        ST_SYNC: begin
          if (line == LS_SE0 || line == LS_SE1) begin
            state_d = ST_IDLE;
          end else if (!dec_bit) begin
            zero_cnt_d = (zero_cnt_q == 3'd7) ? 3'd7 : zero_cnt_q + 3'd1;
          end else if (32'(zero_cnt_q) >= SYNC_MIN_ZEROS) begin
            state_d         = ST_DATA;
            out_d.sop       = 1'b1;
            out_d.rx_active = 1'b1;
            ones_cnt_d      = '0;
            bit_cnt_d       = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DATA: begin
          case (line)
            LS_SE0: begin
              state_d   = ST_EOP;
              se0_cnt_d = 2'd1;
            end
            LS_SE1: begin
              state_d        = ST_IDLE;
              out_d.line_err = 1'b1;
            end
            default: begin
              // After STUFF_LEN ones the next bit must be a stuffed 0.
              if (ones_cnt_q == STUFF_MAX) begin
                if (!dec_bit) begin
                  ones_cnt_d = '0;
                end else begin
                  state_d         = ST_IDLE;
                  out_d.stuff_err = 1'b1;
                end
              end else begin
                out_d.shift  = 1'b1;
                out_d.serial = dec_bit;
                ones_cnt_d   = dec_bit ? ones_cnt_q + 1'b1 : '0;
                bit_cnt_d    = bit_cnt_q + 3'd1;
              end
            end
          endcase
        end
        ST_EOP: begin
          if (line == LS_SE0 && se0_cnt_q < 2'd2) begin
            se0_cnt_d = se0_cnt_q + 2'd1;
          end else if (line == LS_J) begin
            state_d         = ST_IDLE;
            out_d.eop       = 1'b1;
            out_d.align_err = (bit_cnt_q != 3'd0);
          end else begin
            state_d        = ST_IDLE;
            out_d.line_err = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (state_d == ST_IDLE) begin
      zero_cnt_d      = '0;
      ones_cnt_d      = '0;
      bit_cnt_d       = '0;
      se0_cnt_d       = '0;
      out_d.rx_active = 1'b0;
    end
  end

  assign force_j = (state_d == ST_IDLE);

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; nRST only takes effect on a clock edge.
    if (!nRST) begin
      state_q    <= ST_IDLE;
      zero_cnt_q <= '0;
      ones_cnt_q <= '0;
      bit_cnt_q  <= '0;
      se0_cnt_q  <= '0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      zero_cnt_q <= zero_cnt_d;
      ones_cnt_q <= ones_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      se0_cnt_q  <= se0_cnt_d;
      out_q      <= out_d;
    end
  end

  assign serial_out   = out_q.serial;
  assign shift_enable = out_q.shift;
  assign rx_active    = out_q.rx_active;
  assign sop          = out_q.sop;
  assign eop          = out_q.eop;
  assign stuff_err    = out_q.stuff_err;
  assign line_err     = out_q.line_err;
  assign align_err    = out_q.align_err;

endmodule
